// File: rtl/dice_roller.sv
// dice_roller: two-channel dice front end. Each channel synchronises and
// debounces its roll key, animates a face while rolling, latches a final
// face on release and hands it to the score block via the start level.
module dice_roller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ROLL_CYCLES     = 25000000,
  parameter int unsigned SPIN_DIV        = 2500000,
  parameter int unsigned CNT_W           = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  input  logic       hold,
  input  logic       finish,
  output logic [3:0] dice1,
  output logic [3:0] dice2,
  output logic       start1,
  output logic       start2,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE, DONE} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROLL_MAX  = CNT_W'(ROLL_CYCLES);
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_DIV - 1);

  logic [3:0]      face1_q, face1_d;
  logic [3:0]      face2_q, face2_d;
  logic            locked_q, locked_d;
  logic [1:0]      key_in;
  logic [1:0][3:0] face_ch;
  logic [1:0][3:0] dice_ch;
  logic [1:0]      start_ch;
  logic [1:0]      done_ch;

  assign key_in  = {key2, key1};
  assign face_ch = {face2_q, face1_q};

  // Free-running faces: face1 counts up 1..6, face2 counts down 6..1.
  always_comb begin
    face1_d = (face1_q == 4'd6) ? 4'd1 : face1_q + 4'd1;
    face2_d = (face2_q == 4'd1) ? 4'd6 : face2_q - 4'd1;
  end

  // Face registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      face1_q <= 4'd1;
      face2_q <= 4'd6;
    end else begin
      face1_q <= face1_d;
      face2_q <= face2_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] roll_cnt_q, roll_cnt_d;
    logic [CNT_W-1:0] spin_cnt_q, spin_cnt_d;
    logic [3:0]       dice_q, dice_d;
    logic             start_q, start_d;
    logic             press;
    state_e           state_q, state_d;

    // Two-flop synchroniser and previous debounced level for edge detection.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_prev_q <= 1'b0;
      end else begin
        sync1_q    <= key_in[g];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
      end
    end

    // Debounce: count while the synchronised key disagrees, flip on the last count.
    always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) deb_d = ~deb_q;
        else                       deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    // Press is an edge, so a key still held on return to IDLE never rolls.
    assign press = deb_q & ~deb_prev_q;

    // Channel FSM next state, roll/spin counters and face latching.
    always_comb begin
      state_d    = state_q;
      dice_d     = dice_q;
      roll_cnt_d = roll_cnt_q;
      spin_cnt_d = spin_cnt_q;
      case (state_q)
        IDLE: begin
          if (press && !hold) begin
            state_d    = ROLL;
            roll_cnt_d = '0;
            spin_cnt_d = '0;
          end
        end
        ROLL: begin
          if (roll_cnt_q < ROLL_MAX) roll_cnt_d = roll_cnt_q + 1'b1;
          if (!deb_q && (roll_cnt_q >= ROLL_MAX)) begin
            dice_d  = face_ch[g];
            state_d = SETTLE;
          end else if (spin_cnt_q == SPIN_LAST) begin
            dice_d     = face_ch[g];
            spin_cnt_d = '0;
          end else begin
            spin_cnt_d = spin_cnt_q + 1'b1;
          end
        end
        SETTLE:  state_d = DONE;
        DONE:    if (finish) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // start is registered from the next state so it cannot glitch low.
      start_d = (state_d == ROLL) || (state_d == SETTLE);
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q    <= IDLE;
        deb_q      <= 1'b0;
        deb_cnt_q  <= '0;
        roll_cnt_q <= '0;
        spin_cnt_q <= '0;
        dice_q     <= '0;
        start_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        deb_q      <= deb_d;
        deb_cnt_q  <= deb_cnt_d;
        roll_cnt_q <= roll_cnt_d;
        spin_cnt_q <= spin_cnt_d;
        dice_q     <= dice_d;
        start_q    <= start_d;
      end
    end

    assign dice_ch[g]  = dice_q;
    assign start_ch[g] = start_q;
    assign done_ch[g]  = (state_q == DONE);
  end

  // Round lock once both channels have settled.
  always_comb locked_d = done_ch[0] & done_ch[1];

  // Lock register.
  always_ff @(posedge clk) begin
    if (!rst) locked_q <= 1'b0;
    else      locked_q <= locked_d;
  end

  assign dice1  = dice_ch[0];
  assign dice2  = dice_ch[1];
  assign start1 = start_ch[0];
  assign start2 = start_ch[1];
  assign locked = locked_q;

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
Player-side front end for the two-player dice game. It debounces the two roll keys, animates two dice faces while a key is held, and latches a final face (1..6) on release. It drives dice1/dice2 and the start1/start2 levels into the score block, which acts on the falling edge of each start. The round lock is released by the score block's finish pulse.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised key level must stay stable before the debounced level changes (20 ms at 50 MHz)
ROLL_CYCLES, 25000000, minimum cycles a channel stays in ROLL before it may latch (0.5 s)
SPIN_DIV, 2500000, cycles between updates of the animated face on diceN during ROLL
CNT_W, 28, width of the debounce, roll and spin counters

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock domain; reset is synchronous and active-low
key1  input  1  raw roll key, player 1, active-high, asynchronous
key2  input  1  raw roll key, player 2, active-high, asynchronous
hold  input  1  round in progress (from score times); new rolls are refused while 1
finish  input  1  end-of-round pulse from score; re-arms both channels
dice1  output  4  player 1 face; 0 after reset, otherwise 1..6
dice2  output  4  player 2 face; 0 after reset, otherwise 1..6
start1  output  1  high while player 1 is rolling; its falling edge means dice1 is final
start2  output  1  high while player 2 is rolling; its falling edge means dice2 is final
locked  output  1  high when both channels are in DONE

Behaviour:
- Reset (rst=0 at a clk edge) applies on that edge: dice1=dice2=0, start1=start2=0, locked=0, both FSMs in IDLE, all counters 0, face counters at reset value, debounced keys 0.
- Synchronisers: each key passes through a 2-flop synchroniser.
- Debounce: the counter clears whenever the synchronised key equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears. Press and release events are single-cycle rising and falling edges of the debounced level.
- Face counters run every cycle, in every state.
  - face1 counts up 1,2,...,6,1,... with reset value 1.
  - face2 counts down 6,5,...,1,6,... with reset value 6.
  - Mod-6 wrap; values 0 and 7..15 are never produced.
- Per-channel FSM, states IDLE, ROLL, SETTLE, DONE:
  - IDLE: startN=0, diceN holds its value. A press with hold=0 moves to ROLL; next cycle startN=1 and the roll and spin counters clear. A press with hold=1 is ignored. A key already down on entry to IDLE does not roll; a fresh press is required.
  - ROLL: startN=1. The roll counter saturates at ROLL_CYCLES. Each time the spin counter reaches SPIN_DIV-1, diceN <= faceN and the spin counter wraps. Latch condition: debounced key is 0 and roll counter >= ROLL_CYCLES. This covers a release after the minimum time and a release before it (auto-latch on reaching ROLL_CYCLES). On latch, diceN <= faceN in that cycle and the FSM moves to SETTLE.
  - SETTLE: exactly 1 cycle with startN=1 and diceN stable, then startN=0 and the FSM moves to DONE. diceN is therefore stable at least 1 cycle before the start falling edge.
  - DONE: startN=0, diceN held, presses ignored. A cycle with finish=1 moves to IDLE; diceN keeps its value.
- finish in IDLE or ROLL is ignored. finish in SETTLE is ignored and SETTLE still completes.
- locked = (ch1 in DONE) & (ch2 in DONE), registered, so 1 cycle after the second DONE.
- The channels are independent. Simultaneous presses, simultaneous latches, and identical faces are all legal (a tie is resolved in score).
- Reset mid-ROLL forces start low on that edge. No falling-edge glitch may precede it: start goes 1 to 0 only via SETTLE or reset.
- Counter widths: CNT_W must hold max(DEBOUNCE_CYCLES, ROLL_CYCLES, SPIN_DIV); comparisons are unsigned.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, ROLL_CYCLES=20, SPIN_DIV=3, and a model for face1 = ((n mod 6)+1) at n cycles after reset release.
1. key1 high 50 cycles, then low -> start1 rises 7 cycles after the press (2 sync + 4 debounce + 1). dice1 latches face1 at the accepted-release cycle. start1 falls 1 cycle later. dice1 is in 1..6 and stable from then on.
2. key1 high for only 2 cycles -> no debounced press: start1 stays 0, dice1 stays 0.
3. key2 pressed then released after 8 cycles of ROLL -> the latch is deferred until the roll counter reaches 20. start2 is high for about 22 cycles; dice2 equals face2 at the latch cycle.
4. Both keys pressed in the same cycle and released in the same cycle -> both start signals fall in the same cycle. locked=1 one cycle later. Further presses are ignored until a finish pulse, after which a fresh press rolls again.
5. hold=1 and key1 pressed -> ignored. hold drops while the key is still down -> no roll. Release, then press again -> roll starts.
6. rst=0 for 1 cycle mid-ROLL on channel 1 -> start1=0, dice1=0, locked=0 on that edge; the next press rolls normally.
